wb_arbiter: RTL

- Two-master to one-slave Wishbone arbiter that shares the single memory bus between the instruction fetch stage (master 0) and the load/store stage (master 1).
- Sits between the pipeline stages' Wishbone master ports and the system memory/interconnect.
- Holds each grant for the full cycle (cyc high) and resolves contention by fixed or round-robin priority.
- Enforces a bus timeout so a missing slave cannot stall the core.

---
 rtl/wb_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone arbiter: master 0 is instruction fetch, master 1 is load/store.
// A grant is held for the whole cyc; a timeout turns a silent slave into an err.
module wb_arbiter #(
    parameter int ROUND_ROBIN    = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,

    output logic [1:0]  grant_o
);

    // State encoding doubles as the one-hot grant, so grant_o exposes the FSM state directly.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    state_t           next_state;
    logic             last_m1;
    logic [CNT_W-1:0] cnt;
    logic             timeout;
    logic             grant_change;

    // Tie-break: fixed priority favours m1; round-robin favours whoever was not served last.
    function automatic state_t arbitrate(input logic req0, input logic req1, input logic last1);
        state_t pick;
        pick = IDLE;
        if (req0 && req1) begin
            if (ROUND_ROBIN == 0 || !last1) pick = GNT1;
            else                            pick = GNT0;
        end else if (req1) begin
            pick = GNT1;
        end else if (req0) begin
            pick = GNT0;
        end
        return pick;
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = arbitrate(m0_cyc_i, m1_cyc_i, last_m1);
            GNT0:    next_state = m0_cyc_i ? GNT0 : arbitrate(m0_cyc_i, m1_cyc_i, last_m1);
            GNT1:    next_state = m1_cyc_i ? GNT1 : arbitrate(m0_cyc_i, m1_cyc_i, last_m1);
            default: next_state = IDLE;
        endcase
    end

    assign grant_change = (next_state != state);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_m1 <= 1'b0;
        end else if (grant_change && next_state == GNT0) begin
            last_m1 <= 1'b0;
        end else if (grant_change && next_state == GNT1) begin
            last_m1 <= 1'b1;
        end
    end

    assign timeout = (TIMEOUT_CYCLES != 0) && (state != IDLE) && (cnt == CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (state == IDLE || grant_change || s_ack_i || s_err_i || timeout) begin
            cnt <= '0;
        end else if (s_stb_o && TIMEOUT_CYCLES != 0) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Wishbone handshake: a beat completes in the cycle the slave answers a raised stb with
    // ack or err; err (from the slave or the timeout) always masks ack in that same cycle.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        unique case (state)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i & ~s_err_i & ~timeout;
                m0_err_o = s_err_i | timeout;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i & ~s_err_i & ~timeout;
                m1_err_o = s_err_i | timeout;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = state;

endmodule
